// File: rtl/relu_maxpool2x2.sv
// ReLU followed by 2x2/stride-2 max pooling over a row-major pixel stream.
// A half-width line buffer carries top-row pair maxima to the odd row.
module relu_maxpool2x2 #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned MAX_W  = 224,
  parameter int unsigned DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              cfg_err
);

  localparam int unsigned LB_DEPTH = MAX_W / 2;
  localparam int unsigned IDX_W    = $clog2(LB_DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [DIM_W-1:0] w_q, w_nxt, h_q, h_nxt;
  logic [DIM_W-1:0] col, col_nxt, row, row_nxt;
  logic             err_nxt, pix_en;

  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] linebuf [LB_DEPTH];

  logic              cfg_ok;
  logic              last_col, last_row;
  logic [IDX_W-1:0]  lb_idx;
  logic [DATA_W-1:0] relu, top_max, lb_rd, pool_max;

  assign cfg_ok = !cfg_width[0] && !cfg_height[0]
                && (cfg_width >= DIM_W'(2)) && (cfg_width <= DIM_W'(MAX_W))
                && (cfg_height >= DIM_W'(2));

  assign last_col = (col == w_q - DIM_W'(1));
  assign last_row = (row == h_q - DIM_W'(1));

  // Pixel is non-negative after ReLU, so all maxima compare unsigned
  assign relu     = in_data[DATA_W-1] ? '0 : in_data;
  assign top_max  = (hold > relu) ? hold : relu;
  assign lb_idx   = IDX_W'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign pool_max = (top_max > lb_rd) ? top_max : lb_rd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w_q   <= '0;
      h_q   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      w_q   <= w_nxt;
      h_q   <= h_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
    end
  end

  // Next state: start (legal or not) overrides any pixel in the same cycle
  always_comb begin
    state_nxt = state;
    w_nxt     = w_q;
    h_nxt     = h_q;
    col_nxt   = col;
    row_nxt   = row;
    err_nxt   = 1'b0;
    pix_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            state_nxt = RUN;
            w_nxt     = cfg_width;
            h_nxt     = cfg_height;
            col_nxt   = '0;
            row_nxt   = '0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        if (start) begin
          col_nxt = '0;
          row_nxt = '0;
          if (cfg_ok) begin
            w_nxt = cfg_width;
            h_nxt = cfg_height;
          end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end else if (in_valid) begin
          pix_en = 1'b1;
          if (last_col) begin
            col_nxt = '0;
            if (last_row) begin
              row_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              row_nxt = row + DIM_W'(1);
            end
          end else begin
            col_nxt = col + DIM_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output and pooling registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      cfg_err   <= err_nxt;
      busy      <= (state_nxt == RUN);
      if (pix_en) begin
        if (!col[0]) begin
          hold <= relu;
        end else if (row[0]) begin
          out_valid <= 1'b1;
          out_data  <= pool_max;
          out_last  <= last_row && last_col;
        end
      end
    end
  end

  // Line buffer: no reset, every entry is written on the even row before use
  always_ff @(posedge clk) begin
    if (pix_en && col[0] && !row[0]) begin
      linebuf[lb_idx] <= top_max;
    end
  end

endmodule
